multi_channel_timer: RTL and testbench
======================================

Name: multi_channel_timer

Overview:
- Parametrised successor to the single-channel seconds timer.
- NUM_CH independent countdown channels share one prescaler that turns the system clock into a TICK_HZ tick.
- Each channel adds CNT_W-bit load values, one-shot or periodic (auto-reload) mode, pause, and cancel.
- Drives seven-segment countdowns, LED heartbeats and capture-interval sequencing in the camera top level.

Parameters:
- CLK_FREQ_HZ, 65_000_000, system clock frequency in Hz.
- TICK_HZ, 1, tick rate. PERIOD = CLK_FREQ_HZ/TICK_HZ, integer, must be >= 2.
- NUM_CH, 4, number of independent channels, 1..16.
- CNT_W, 8, width of each channel's load value and count.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  NUM_CH  per-channel load-and-run strobe, one cycle.
- cancel  in  NUM_CH  per-channel stop-and-clear strobe.
- pause  in  NUM_CH  level; while high the channel holds its count.
- periodic  in  NUM_CH  mode per channel, sampled at start: 1 = auto-reload, 0 = one-shot.
- value  in  NUM_CH*CNT_W  load values; channel i uses bits [i*CNT_W +: CNT_W].
- counting  out  NUM_CH  channel is running; stays high while paused.
- expired_pulse  out  NUM_CH  one-cycle pulse when a count reaches zero.
- count_out  out  NUM_CH*CNT_W  current count per channel.
- tick  out  1  one-cycle pulse, once per PERIOD clocks.

Behaviour:
- Reset (async assert, sync release): prescaler = 0; all outputs 0; per-channel reload registers and mode registers = 0.

Prescaler:
- Free-running counter 0..PERIOD-1, never stopped by channel activity.
- Internal tick_int is high in the cycle the counter equals PERIOD-1; it then wraps to 0.
- The tick port is tick_int registered, so it appears one cycle later.

Per-channel FSM, states IDLE and RUN. PAUSED is RUN with the pause input high. Priority per cycle is reset > start > cancel > tick.

start[i] in cycle N (any state):
- Effects at N+1: count_out = value_i; reload_i = value_i; mode_i = periodic[i].
- If value_i != 0: counting = 1 at N+1, state RUN. A running channel restarts and its partial tick is lost; the prescaler phase is not reset.
- If value_i == 0: expired_pulse = 1 at N+1, counting = 0, state IDLE.

cancel[i] without start[i]:
- At the next cycle: count_out = 0, counting = 0, state IDLE, no expired_pulse.
- No effect in IDLE.

In RUN, with pause[i] low and tick_int high:
- count > 1: count decrements by 1.
- count == 1, one-shot: next cycle count = 0, counting = 0, expired_pulse = 1, state IDLE.
- count == 1, periodic: next cycle count = reload_i, counting stays 1, expired_pulse = 1.

Pause:
- While pause[i] is high, ticks are ignored and the count holds.
- start and cancel still act during pause.
- Releasing pause does not produce a catch-up decrement.

General rules:
- expired_pulse is never high for two consecutive cycles from one expiry.
- A start in the cycle that would expire the channel suppresses that expiry pulse, because start wins.
- Channels are fully independent. Simultaneous expiries on several channels each pulse in the same cycle.
- Count arithmetic is unsigned CNT_W and never wraps below 0. The IDLE count is 0 after an expiry or cancel.
- A load value of all ones, e.g. 255 for CNT_W = 8, is legal: it gives 255 ticks.

Test Plan:
Every scenario uses CLK_FREQ_HZ = 10, TICK_HZ = 1 (tick every 10 clocks) and NUM_CH = 4, CNT_W = 8.

1. Reset and tick: release reset_n, run 40 clocks -> tick pulses exactly 4 times, 10 clocks apart. Every other output stays 0. Assert reset_n low mid-count -> all outputs 0 immediately, without waiting for a clock edge.
2. One-shot: start[0] with value 3 -> next cycle count_out[0] = 3 and counting[0] = 1. Count goes 2, 1, 0 on successive ticks. expired_pulse[0] is a single cycle coincident with count 0, and counting[0] falls then.
3. Periodic: start[1] with value 2, periodic = 1 -> expired_pulse[1] every 20 clocks, 5 times over 100 clocks. The count after each expiry is 2. counting[1] never drops.
4. Pause and cancel: channel 2 loaded with 5; hold pause[2] across 3 ticks -> count stays frozen, resumes on release, no catch-up decrement. Then cancel[2] -> count 0, counting 0, no expired_pulse.
5. Edge cases:
   - start[3] with value 0 -> one expired_pulse next cycle, counting stays 0.
   - start and cancel in the same cycle -> start wins.
   - Restart in the cycle count is 1 and tick is high -> no pulse, count = new value.
6. Concurrency: all 4 channels started with value 1 in the same cycle -> all expired_pulse bits are high in the same single cycle.

Source files
------------

// File: rtl/multi_channel_timer.sv
// Multi-channel countdown timer: one shared prescaler produces a tick, and each
// channel counts its own load value down in one-shot or auto-reload mode.
module multi_channel_timer #(
  parameter int unsigned CLK_FREQ_HZ = 65_000_000,
  parameter int unsigned TICK_HZ     = 1,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_CH-1:0]         start,
  input  logic [NUM_CH-1:0]         cancel,
  input  logic [NUM_CH-1:0]         pause,
  input  logic [NUM_CH-1:0]         periodic,
  input  logic [NUM_CH*CNT_W-1:0]   value,
  output logic [NUM_CH-1:0]         counting,
  output logic [NUM_CH-1:0]         expired_pulse,
  output logic [NUM_CH*CNT_W-1:0]   count_out,
  output logic                      tick
);

  localparam int unsigned PERIOD = CLK_FREQ_HZ / TICK_HZ;
  localparam int unsigned PRE_W  = $clog2(PERIOD);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PERIOD - 1);

  typedef enum logic {IDLE, RUN} state_t;

  logic [PRE_W-1:0] pre_q;
  logic             tick_int;

  state_t           state_q  [NUM_CH];
  state_t           state_d  [NUM_CH];
  logic [CNT_W-1:0] count_q  [NUM_CH];
  logic [CNT_W-1:0] count_d  [NUM_CH];
  logic [CNT_W-1:0] reload_q [NUM_CH];
  logic [CNT_W-1:0] reload_d [NUM_CH];
  logic [NUM_CH-1:0] mode_q, mode_d;
  logic [NUM_CH-1:0] pulse_q, pulse_d;

  // Prescaler free-runs regardless of channel activity.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pre_q <= '0;
      tick  <= 1'b0;
    end else begin
      pre_q <= tick_int ? '0 : pre_q + PRE_W'(1);
      tick  <= tick_int;
    end
  end

  assign tick_int = (pre_q == PRE_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_q[i]  <= IDLE;
        count_q[i]  <= '0;
        reload_q[i] <= '0;
      end
      mode_q  <= '0;
      pulse_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_q[i]  <= state_d[i];
        count_q[i]  <= count_d[i];
        reload_q[i] <= reload_d[i];
      end
      mode_q  <= mode_d;
      pulse_q <= pulse_d;
    end
  end

  // Per-channel priority: start, then cancel, then a tick decrement.
  always_comb begin
    mode_d  = mode_q;
    pulse_d = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      state_d[i]  = state_q[i];
      count_d[i]  = count_q[i];
      reload_d[i] = reload_q[i];
      if (start[i]) begin
        count_d[i]  = value[i*CNT_W +: CNT_W];
        reload_d[i] = value[i*CNT_W +: CNT_W];
        mode_d[i]   = periodic[i];
        if (value[i*CNT_W +: CNT_W] != '0) begin
          state_d[i] = RUN;
        end else begin
          state_d[i] = IDLE;
          pulse_d[i] = 1'b1;
        end
      end else if (cancel[i] && state_q[i] == RUN) begin
        count_d[i] = '0;
        state_d[i] = IDLE;
      end else if (state_q[i] == RUN && !pause[i] && tick_int) begin
        if (count_q[i] > CNT_W'(1)) begin
          count_d[i] = count_q[i] - CNT_W'(1);
        end else begin
          pulse_d[i] = 1'b1;
          if (mode_q[i]) begin
            count_d[i] = reload_q[i];
          end else begin
            count_d[i] = '0;
            state_d[i] = IDLE;
          end
        end
      end
    end
  end

  always_comb begin
    counting  = '0;
    count_out = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      counting[i]                    = (state_q[i] == RUN);
      count_out[i*CNT_W +: CNT_W]    = count_q[i];
    end
    expired_pulse = pulse_q;
  end

endmodule

// File: tb/tb_multi_channel_timer.sv
// Bench for multi_channel_timer: directed scenarios plus random traffic, all
// checked against a ticks-remaining reference model.
module tb_multi_channel_timer;

  localparam int unsigned NCH = 4;
  localparam int unsigned W   = 8;
  localparam int unsigned P   = 10;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [NCH-1:0]    start = '0;
  logic [NCH-1:0]    cancel = '0;
  logic [NCH-1:0]    pause = '0;
  logic [NCH-1:0]    periodic = '0;
  logic [NCH*W-1:0]  value = '0;
  logic [NCH-1:0]    counting;
  logic [NCH-1:0]    expired_pulse;
  logic [NCH*W-1:0]  count_out;
  logic              tick;

  multi_channel_timer #(
    .CLK_FREQ_HZ (10),
    .TICK_HZ     (1),
    .NUM_CH      (NCH),
    .CNT_W       (W)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .start         (start),
    .cancel        (cancel),
    .pause         (pause),
    .periodic      (periodic),
    .value         (value),
    .counting      (counting),
    .expired_pulse (expired_pulse),
    .count_out     (count_out),
    .tick          (tick)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: cycles since reset, ticks remaining per channel.
  int           m_k;
  int           rem [NCH];
  bit           run [NCH];
  int           rel [NCH];
  bit           per [NCH];
  bit           e_tick;
  bit [NCH-1:0] e_pulse;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_k = 0;
    e_tick = 1'b0;
    e_pulse = '0;
    for (int i = 0; i < NCH; i++) begin
      rem[i] = 0; run[i] = 1'b0; rel[i] = 0; per[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit tint;
    int v;
    tint = ((m_k % P) == P - 1);
    m_k++;
    e_tick = tint;
    e_pulse = '0;
    for (int i = 0; i < NCH; i++) begin
      v = int'(value[i*W +: W]);
      if (start[i]) begin
        rem[i] = v; rel[i] = v; per[i] = periodic[i];
        if (v != 0) run[i] = 1'b1;
        else begin run[i] = 1'b0; e_pulse[i] = 1'b1; end
      end else if (cancel[i] && run[i]) begin
        rem[i] = 0; run[i] = 1'b0;
      end else if (run[i] && !pause[i] && tint) begin
        rem[i] = rem[i] - 1;
        if (rem[i] == 0) begin
          e_pulse[i] = 1'b1;
          if (per[i]) rem[i] = rel[i];
          else run[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("tick", 32'(tick), 32'(e_tick));
    for (int i = 0; i < NCH; i++) begin
      check($sformatf("counting%0d", i), 32'(counting[i]), 32'(run[i]));
      check($sformatf("expired%0d", i), 32'(expired_pulse[i]), 32'(e_pulse[i]));
      check($sformatf("count%0d", i), 32'(count_out[i*W +: W]), 32'(rem[i]));
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clock);
    #1;
    compare_all();
    start = '0;
    cancel = '0;
  endtask

  // Steps until the next step is one in which the prescaler ticks.
  task automatic advance_to_tick();
    for (int n = 0; n < P; n++) begin
      if ((m_k % P) == P - 1) break;
      step();
    end
  endtask

  task automatic set_val(input int ch, input int v);
    logic [W-1:0] vv;
    vv = W'(v);
    value[ch*W +: W] = vv;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tick"}, 32'(tick), 32'd0);
    check({tag, "_counting"}, 32'(counting), 32'd0);
    check({tag, "_expired"}, 32'(expired_pulse), 32'd0);
    check({tag, "_count"}, 32'(count_out), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int ntick, last, gap_bad, npulse, frozen, r;
    model_reset();
    #8;
    check_all_zero("reset");
    #4;
    reset_n = 1'b1;

    // Tick cadence with idle channels.
    ntick = 0; last = -1; gap_bad = 0;
    for (int n = 0; n < 40; n++) begin
      step();
      if (tick === 1'b1) begin
        if (last >= 0 && n - last != P) gap_bad++;
        last = n;
        ntick++;
      end
    end
    check("tick_count", 32'(ntick), 32'd4);
    check("tick_gap", 32'(gap_bad), 32'd0);

    // One-shot countdown from 3.
    set_val(0, 3); periodic[0] = 1'b0; start[0] = 1'b1;
    step();
    check("oneshot_load", 32'(count_out[0 +: W]), 32'd3);
    for (int n = 0; n < 35; n++) step();
    check("oneshot_done", 32'(counting[0]), 32'd0);

    // Periodic reload of 2: five expiries in 100 clocks.
    set_val(1, 2); periodic[1] = 1'b1; start[1] = 1'b1;
    step();
    npulse = 0;
    for (int n = 0; n < 100; n++) begin
      step();
      if (expired_pulse[1] === 1'b1) npulse++;
    end
    check("periodic_pulses", 32'(npulse), 32'd5);
    periodic[1] = 1'b0;

    // Asynchronous reset while channel 1 is running.
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    model_reset();

    // Pause holds the count across several ticks; cancel clears silently.
    set_val(2, 5); start[2] = 1'b1;
    step();
    advance_to_tick();
    step();
    pause[2] = 1'b1;
    frozen = int'(count_out[2*W +: W]);
    for (int n = 0; n < 30; n++) step();
    check("pause_frozen", 32'(count_out[2*W +: W]), 32'(frozen));
    pause[2] = 1'b0;
    advance_to_tick();
    step();
    check("pause_resume", 32'(count_out[2*W +: W]), 32'(frozen - 1));
    cancel[2] = 1'b1;
    step();
    check("cancel_count", 32'(count_out[2*W +: W]), 32'd0);
    check("cancel_nopulse", 32'(expired_pulse[2]), 32'd0);

    // Zero load expires at once.
    set_val(3, 0); start[3] = 1'b1;
    step();
    check("zero_pulse", 32'(expired_pulse[3]), 32'd1);
    check("zero_counting", 32'(counting[3]), 32'd0);
    step();
    check("zero_single", 32'(expired_pulse[3]), 32'd0);

    // Start beats cancel in the same cycle.
    set_val(2, 4); start[2] = 1'b1; cancel[2] = 1'b1;
    step();
    check("start_cancel_run", 32'(counting[2]), 32'd1);
    check("start_cancel_cnt", 32'(count_out[2*W +: W]), 32'd4);

    // Restart exactly when count is 1 and the tick arrives.
    set_val(3, 1); start[3] = 1'b1;
    step();
    advance_to_tick();
    set_val(3, 9); start[3] = 1'b1;
    step();
    check("restart_nopulse", 32'(expired_pulse[3]), 32'd0);
    check("restart_count", 32'(count_out[3*W +: W]), 32'd9);

    // All channels expire together.
    for (int i = 0; i < NCH; i++) set_val(i, 1);
    start = '1;
    step();
    advance_to_tick();
    step();
    check("concurrent_pulse", 32'(expired_pulse), 32'hF);
    step();
    check("concurrent_single", 32'(expired_pulse), 32'h0);

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NCH; i++) begin
        if ($urandom % 25 == 0) begin
          r = int'($urandom % 16);
          if (r == 0) set_val(i, 0);
          else if (r == 1) set_val(i, 255);
          else set_val(i, 1 + int'($urandom % 4));
          periodic[i] = 1'($urandom % 2);
          start[i] = 1'b1;
        end
        if ($urandom % 40 == 0) cancel[i] = 1'b1;
        if ($urandom % 15 == 0) pause[i] = ~pause[i];
      end
      step();
    end
    pause = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
